fetch_req_sequencer: RTL and testbench

//  Sequences instruction-fetch reads on the single memory read port for the front end, ahead of decode.

---
 rtl/fetch_req_sequencer.sv | 157 +++++++++++++++
 tb/tb_fetch_req_sequencer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_req_sequencer.sv
// Instruction-fetch request sequencer: owns the fetch PC, issues aligned 64-bit reads under a
// credit limit, pairs in-order responses with their PCs and hands instructions to decode.
module fetch_req_sequencer #(
   parameter int          DEPTH    = 4,
   parameter logic [63:0] RESET_PC = 64'd8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        fetch_en,
   input  logic        set_pc_valid,
   input  logic [63:0] set_pc,
   output logic        mem_rien,
   output logic [63:0] mem_riaddr,
   input  logic        mem_rivalid,
   input  logic [63:0] mem_ridata,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [63:0] out_pc,
   output logic        err_unexp_rsp
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   function automatic logic [31:0] word_sel(input logic [63:0] data, input logic hi);
      logic [31:0] w;
      if (hi) begin
         w = data[63:32];
      end else begin
         w = data[31:0];
      end
      return w;
   endfunction

   logic [63:0]       pc_r;
   logic [63:0]       pc_mem_r   [DEPTH];
   logic [63:0]       data_mem_r [DEPTH];
   logic [DEPTH-1:0]  filled_r;
   logic [PW-1:0]     head_r, tail_r, fill_r;
   logic [CW-1:0]     used_r;
   logic [CW-1:0]     live_r;
   logic [CW-1:0]     drop_r;
   logic              err_r;

   logic [CW:0]       credit_s;
   logic [CW:0]       redir_total_s;
   logic [CW:0]       drop_redir_s;
   logic              issue_s;
   logic              pop_s;
   logic              rsp_drop_s;
   logic              rsp_fill_s;
   logic              rsp_unexp_s;

   // Credit check, response classification and head presentation.
   always_comb begin
      credit_s      = {1'b0, used_r} + {1'b0, drop_r};
      redir_total_s = {1'b0, live_r} + {1'b0, drop_r};
      drop_redir_s  = redir_total_s;
      mem_rien      = 1'b0;
      out_valid     = 1'b0;
      rsp_drop_s    = 1'b0;
      rsp_fill_s    = 1'b0;
      rsp_unexp_s   = 1'b0;

      if (!rst && fetch_en && !set_pc_valid && (credit_s < (CW+1)'(DEPTH))) begin
         mem_rien = 1'b1;
      end else begin
         mem_rien = 1'b0;
      end
      issue_s = mem_rien;

      if (used_r != {CW{1'b0}}) begin
         out_valid = filled_r[head_r];
      end else begin
         out_valid = 1'b0;
      end
      pop_s = out_valid & out_ready & ~set_pc_valid;

      // Stale reads are retired first; a response with nothing owed is flagged and ignored.
      if (mem_rivalid) begin
         if (drop_r != {CW{1'b0}}) begin
            rsp_drop_s = 1'b1;
         end else if (live_r != {CW{1'b0}}) begin
            rsp_fill_s = ~set_pc_valid;
         end else begin
            rsp_unexp_s = 1'b1;
         end
      end else begin
         rsp_drop_s = 1'b0;
      end

      if (mem_rivalid && (redir_total_s != {(CW+1){1'b0}})) begin
         drop_redir_s = redir_total_s - (CW+1)'(1'b1);
      end else begin
         drop_redir_s = redir_total_s;
      end
   end

   assign mem_riaddr    = {pc_r[63:3], 3'b000};
   assign out_pc        = pc_mem_r[head_r];
   assign out_instr     = word_sel(data_mem_r[head_r], pc_mem_r[head_r][2]);
   assign err_unexp_rsp = err_r;

   // Fetch PC, entry buffer, pointers and credit counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_r     <= RESET_PC;
         head_r   <= {PW{1'b0}};
         tail_r   <= {PW{1'b0}};
         fill_r   <= {PW{1'b0}};
         used_r   <= {CW{1'b0}};
         live_r   <= {CW{1'b0}};
         drop_r   <= {CW{1'b0}};
         err_r    <= 1'b0;
         filled_r <= {DEPTH{1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            pc_mem_r[i]   <= 64'd0;
            data_mem_r[i] <= 64'd0;
         end
      end else begin
         if (rsp_unexp_s) begin
            err_r <= 1'b1;
         end
         if (set_pc_valid) begin
            pc_r   <= set_pc;
            head_r <= {PW{1'b0}};
            tail_r <= {PW{1'b0}};
            fill_r <= {PW{1'b0}};
            used_r <= {CW{1'b0}};
            live_r <= {CW{1'b0}};
            drop_r <= drop_redir_s[CW-1:0];
         end else begin
            if (issue_s) begin
               pc_mem_r[tail_r] <= pc_r;
               filled_r[tail_r] <= 1'b0;
               tail_r           <= tail_r + PW'(1'b1);
               pc_r             <= pc_r + 64'd4;
            end
            if (rsp_drop_s) begin
               drop_r <= drop_r - CW'(1'b1);
            end
            if (rsp_fill_s) begin
               data_mem_r[fill_r] <= mem_ridata;
               filled_r[fill_r]   <= 1'b1;
               fill_r             <= fill_r + PW'(1'b1);
            end
            if (pop_s) begin
               head_r <= head_r + PW'(1'b1);
            end
            used_r <= used_r + CW'(issue_s) - CW'(pop_s);
            live_r <= live_r + CW'(issue_s) - CW'(rsp_fill_s);
         end
      end
   end

endmodule

// File: tb/tb_fetch_req_sequencer.sv
// Scoreboard bench for fetch_req_sequencer: an in-order memory model with random latency, a PC
// reference model feeding an expected-instruction queue, and a monitor checking what decode sees.
module tb_fetch_req_sequencer;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst, fetch_en, set_pc_valid, out_ready, mem_rivalid;
   logic [63:0] set_pc, mem_ridata;
   logic        mem_rien, out_valid, err_unexp_rsp;
   logic [63:0] mem_riaddr, out_pc;
   logic [31:0] out_instr;

   fetch_req_sequencer #(.DEPTH(DEPTH), .RESET_PC(64'd8)) dut (
      .clk(clk), .rst(rst), .fetch_en(fetch_en), .set_pc_valid(set_pc_valid), .set_pc(set_pc),
      .mem_rien(mem_rien), .mem_riaddr(mem_riaddr), .mem_rivalid(mem_rivalid),
      .mem_ridata(mem_ridata), .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .out_pc(out_pc), .err_unexp_rsp(err_unexp_rsp));

   always #5 clk = ~clk;

   typedef struct {logic [63:0] pc; logic [31:0] instr; bit filled;} exp_t;
   typedef struct {logic [63:0] addr; int epoch; int due;} req_t;

   exp_t        exp_q[$];
   req_t        pend_q[$];
   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   int          epoch = 0;
   int          lat_min = 1;
   int          lat_max = 1;
   logic [63:0] ref_pc = 64'd8;
   bit          err_exp = 1'b0;
   bit          mon_popped = 1'b0;

   function automatic logic [63:0] mem_word(input logic [63:0] a);
      return {a[63:32] ^ a[31:0] ^ 32'h1234_5678, ~a[31:0] ^ 32'h0BAD_F00D};
   endfunction

   function automatic logic [31:0] exp_instr(input logic [63:0] pc);
      logic [63:0] w;
      w = mem_word({pc[63:3], 3'b000});
      return pc[2] ? w[63:32] : w[31:0];
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: compares the presented head against the scoreboard and pops on acceptance.
   always @(negedge clk) begin
      bit ev;
      ev = 1'b0;
      if (!rst) begin
         ev = (exp_q.size() > 0) && exp_q[0].filled;
         check("out_valid", out_valid, ev);
         if (out_valid && ev) begin
            check("out_pc", out_pc, exp_q[0].pc);
            check("out_instr", out_instr, exp_q[0].instr);
            if (out_ready && !set_pc_valid) begin
               void'(exp_q.pop_front());
               mon_popped = 1'b1;
            end
         end
      end
   end

   // Reference model: credits, PC sequence, response pairing and redirect flushing.
   always begin : model
      int   stale;
      int   used_pre;
      bit   exp_rien;
      req_t r;
      @(negedge clk);
      #1;
      check("err_unexp_rsp", err_unexp_rsp, err_exp);
      if (rst) begin
         check("rien_in_rst", mem_rien, 64'd0);
         exp_q.delete();
         pend_q.delete();
         ref_pc     = 64'd8;
         err_exp    = 1'b0;
         mon_popped = 1'b0;
         epoch++;
      end else begin
         stale = 0;
         foreach (pend_q[i]) if (pend_q[i].epoch != epoch) stale++;
         used_pre   = exp_q.size() + (mon_popped ? 1 : 0);
         mon_popped = 1'b0;
         exp_rien   = fetch_en && !set_pc_valid && (used_pre + stale < DEPTH);
         check("mem_rien", mem_rien, exp_rien);
         if (used_pre + stale > DEPTH) check("credit_bound", used_pre + stale, DEPTH);
         if (mem_rivalid) begin
            if (pend_q.size() == 0) begin
               err_exp = 1'b1;
            end else begin
               r = pend_q.pop_front();
               if (!set_pc_valid && r.epoch == epoch) begin
                  for (int i = 0; i < exp_q.size(); i++) begin
                     if (!exp_q[i].filled) begin
                        exp_q[i].filled = 1'b1;
                        break;
                     end
                  end
               end
            end
         end
         if (mem_rien) begin
            check("mem_riaddr", mem_riaddr, {ref_pc[63:3], 3'b000});
            exp_q.push_back('{pc: ref_pc, instr: exp_instr(ref_pc), filled: 1'b0});
            pend_q.push_back('{addr: {ref_pc[63:3], 3'b000}, epoch: epoch,
                               due: cyc + $urandom_range(lat_max, lat_min)});
            ref_pc = ref_pc + 64'd4;
         end
         if (set_pc_valid) begin
            ref_pc = set_pc;
            exp_q.delete();
            epoch++;
         end
      end
   end

   task automatic step(input bit r, input bit fe, input bit rdy, input bit spv,
                       input logic [63:0] spc, input bit spur);
      @(posedge clk);
      #1;
      rst          = r;
      fetch_en     = fe;
      out_ready    = rdy;
      set_pc_valid = spv;
      set_pc       = spc;
      if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
         mem_rivalid = 1'b1;
         mem_ridata  = mem_word(pend_q[0].addr);
      end else if (spur) begin
         mem_rivalid = 1'b1;
         mem_ridata  = {$urandom, $urandom};
      end else begin
         mem_rivalid = 1'b0;
         mem_ridata  = 64'd0;
      end
   endtask

   initial begin
      logic [63:0] spc;
      rst = 1'b1; fetch_en = 1'b0; out_ready = 1'b0; set_pc_valid = 1'b0;
      set_pc = 64'd0; mem_rivalid = 1'b0; mem_ridata = 64'd0;
      repeat (3) step(1, 0, 0, 0, 64'd0, 0);
      @(negedge clk);
      check("rst_rien", mem_rien, 64'd0);
      check("rst_out_valid", out_valid, 64'd0);
      check("rst_out_instr", out_instr, 64'd0);
      check("rst_err", err_unexp_rsp, 64'd0);

      // Streaming at latency 1, then backpressure at latency 3.
      lat_min = 1; lat_max = 1;
      repeat (30) step(0, 1, 1, 0, 64'd0, 0);
      lat_min = 3; lat_max = 3;
      repeat (20) step(0, 1, 0, 0, 64'd0, 0);
      repeat (20) step(0, 1, 1, 0, 64'd0, 0);

      // Redirect with reads in flight, then redirect into a response+pop cycle and across PC wrap.
      repeat (2) step(0, 1, 1, 0, 64'd0, 0);
      step(0, 1, 1, 1, 64'h100, 0);
      repeat (20) step(0, 1, 1, 0, 64'd0, 0);
      lat_min = 1; lat_max = 1;
      repeat (10) step(0, 1, 1, 0, 64'd0, 0);
      step(0, 1, 1, 1, 64'h200, 0);
      repeat (10) step(0, 1, 1, 0, 64'd0, 0);
      step(0, 1, 1, 1, 64'hFFFF_FFFF_FFFF_FFF8, 0);
      repeat (12) step(0, 1, 1, 0, 64'd0, 0);

      // Random traffic.
      lat_min = 1; lat_max = 5;
      for (int n = 0; n < 10000; n++) begin
         spc = {$urandom, $urandom} & ~64'd3;
         if ($urandom_range(0, 7) == 0) spc = 64'hFFFF_FFFF_FFFF_FFF0 | (64'($urandom_range(0, 3)) << 2);
         step(0, $urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0,
              $urandom_range(0, 29) == 0, spc, 0);
      end

      // Drain, then a response with nothing outstanding.
      repeat (30) step(0, 0, 1, 0, 64'd0, 0);
      @(negedge clk);
      check("drain_exp_q", exp_q.size(), 64'd0);
      check("drain_pend_q", pend_q.size(), 64'd0);
      step(0, 0, 1, 0, 64'd0, 1);
      repeat (4) step(0, 0, 1, 0, 64'd0, 0);
      @(negedge clk);
      check("err_sticky", err_unexp_rsp, 64'd1);
      check("err_no_fill", out_valid, 64'd0);
      step(1, 0, 1, 0, 64'd0, 0);
      repeat (2) step(0, 0, 1, 0, 64'd0, 0);
      @(negedge clk);
      check("err_cleared", err_unexp_rsp, 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
